// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the ifu and lsu request/response channels onto one memory port.
// Ports: clock/reset (async active-low).
// Fetch channel: ifu_reqValid/ifu_addr in, ifu_respValid/ifu_rdata out.
// Load/store channel: lsu_reqValid/addr/size/wen/wdata/wmask in, lsu_respValid/lsu_rdata out.
// Memory side: mem_reqValid/addr/size/wen/wdata/wmask out, mem_reqReady in,
// mem_respValid/mem_rdata in.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [1:0]          lsu_size,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  input  logic                mem_reqReady,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [1:0]          mem_size,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;
  // owner / last_grant encoding: 0 = ifu, 1 = lsu
  logic pend_ifu, pend_lsu, owner, last_grant;
  logic [ADDR_W-1:0]   ifu_addr_q, lsu_addr_q;
  logic [1:0]          lsu_size_q;
  logic                lsu_wen_q;
  logic [DATA_W-1:0]   lsu_wdata_q;
  logic [DATA_W/8-1:0] lsu_wmask_q;
  logic grant, win_lsu, cap_ifu, cap_lsu, resp;
  // lsu wins a tie only when ifu had the previous grant
  assign win_lsu = pend_lsu && (!pend_ifu || !last_grant);
  assign grant   = (state == IDLE) && (pend_ifu || pend_lsu);
  // a channel that already owns the bus or has a pending entry drops new pulses
  assign cap_ifu = ifu_reqValid && !pend_ifu && !((state != IDLE) && !owner);
  assign cap_lsu = lsu_reqValid && !pend_lsu && !((state != IDLE) && owner);
  assign resp    = (state == WAIT) && mem_respValid;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (grant ? REQ : IDLE) :
                (state == REQ)  ? (mem_reqReady ? WAIT : REQ) :
                                  (mem_respValid ? IDLE : WAIT);
  always_comb mem_reqValid = (state == REQ);
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pend_ifu      <= 1'b0;
      pend_lsu      <= 1'b0;
      owner         <= 1'b0;
      last_grant    <= 1'b0;
      ifu_addr_q    <= '0;
      lsu_addr_q    <= '0;
      lsu_size_q    <= '0;
      lsu_wen_q     <= 1'b0;
      lsu_wdata_q   <= '0;
      lsu_wmask_q   <= '0;
      mem_addr      <= '0;
      mem_size      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_respValid <= 1'b0;
      lsu_respValid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rdata     <= '0;
    end else begin
      pend_ifu <= cap_ifu ? 1'b1 : (grant && !win_lsu) ? 1'b0 : pend_ifu;
      pend_lsu <= cap_lsu ? 1'b1 : (grant && win_lsu) ? 1'b0 : pend_lsu;
      if (cap_ifu) ifu_addr_q <= ifu_addr;
      if (cap_lsu) begin
        lsu_addr_q  <= lsu_addr;
        lsu_size_q  <= lsu_size;
        lsu_wen_q   <= lsu_wen;
        lsu_wdata_q <= lsu_wdata;
        lsu_wmask_q <= lsu_wmask;
      end
      if (grant) begin
        owner      <= win_lsu;
        last_grant <= win_lsu;
        mem_addr   <= win_lsu ? lsu_addr_q : ifu_addr_q;
        mem_size   <= win_lsu ? lsu_size_q : 2'd2;
        mem_wen    <= win_lsu && lsu_wen_q;
        mem_wdata  <= win_lsu ? lsu_wdata_q : '0;
        mem_wmask  <= win_lsu ? lsu_wmask_q : '0;
      end
      ifu_respValid <= resp && !owner;
      lsu_respValid <= resp && owner;
      if (resp && !owner) ifu_rdata <= mem_rdata;
      if (resp && owner)  lsu_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;
  logic        clock = 0, reset = 1;
  logic        ifu_reqValid = 0, ifu_respValid;
  logic [31:0] ifu_addr = 0, ifu_rdata;
  logic        lsu_reqValid = 0, lsu_wen = 0, lsu_respValid;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
  logic [1:0]  lsu_size = 0;
  logic [3:0]  lsu_wmask = 0;
  logic        mem_reqValid, mem_reqReady = 1, mem_wen, mem_respValid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wmask;
  logic        av = 0, mv = 0;
  logic [31:0] ad = 0, md = 0;
  assign mem_respValid = av | mv;
  assign mem_rdata     = mv ? md : ad;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr),
    .ifu_respValid(ifu_respValid), .ifu_rdata(ifu_rdata),
    .lsu_reqValid(lsu_reqValid), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_respValid(lsu_respValid), .lsu_rdata(lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_reqReady(mem_reqReady),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic ch; logic [31:0] data; int cyc; } rsp_t;
  typedef struct packed {
    logic [31:0] addr; logic [31:0] wdata; logic wen; logic [1:0] size; logic [3:0] wmask; int cyc;
  } hs_t;
  rsp_t rsp_q[$];
  hs_t  hs_q[$];
  int cyc = 0, n_vec = 0, n_err = 0, resp_delay = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ifu_respValid) rsp_q.push_back('{1'b0, ifu_rdata, cyc});
    if (lsu_respValid) rsp_q.push_back('{1'b1, lsu_rdata, cyc});
    if (mem_reqValid && mem_reqReady)
      hs_q.push_back('{mem_addr, mem_wdata, mem_wen, mem_size, mem_wmask, cyc});
  end

  function automatic logic [31:0] model(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0013;
      32'h0000_0300: return 32'h1122_3344;
      32'h0000_0104: return 32'h5566_7788;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // memory model: response resp_delay cycles after the cycle following the handshake
  initial forever begin : responder
    logic [31:0] d;
    @(negedge clock);
    if (reset && mem_reqValid && mem_reqReady) begin
      d = model(mem_addr);
      @(posedge clock); #1;
      repeat (resp_delay) begin @(posedge clock); #1; end
      av = 1; ad = d;
      @(posedge clock); #1;
      av = 0;
    end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic do_reset;
    ifu_reqValid = 0; lsu_reqValid = 0; mem_reqReady = 1; mv = 0;
    reset = 0; tick; tick;
    reset = 1; tick;
    rsp_q.delete(); hs_q.delete();
  endtask

  task automatic test_reset;
    logic [139:0] outs;
    #2 reset = 0;
    for (int i = 0; i < 3; i++) begin
      ifu_reqValid = 1'($urandom); ifu_addr = $urandom;
      lsu_reqValid = 1'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;
      lsu_size = 2'($urandom); lsu_wen = 1'($urandom); lsu_wmask = 4'($urandom);
      mem_reqReady = 1'($urandom); mv = 1'($urandom); md = $urandom;
      tick;
      outs = {ifu_respValid, ifu_rdata, lsu_respValid, lsu_rdata, mem_reqValid,
              mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask};
      n_vec++;
      if (outs !== '0) begin n_err++; $display("FAIL reset_outputs cycle %0d: got %h, want 0", i, outs); end
    end
    ifu_reqValid = 0; lsu_reqValid = 0; mv = 0; mem_reqReady = 1; resp_delay = 0;
    reset = 1; tick;
    rsp_q.delete(); hs_q.delete();
    ifu_reqValid = 1; ifu_addr = 32'h8000_0000;
    tick; ifu_reqValid = 0;
    n_vec++;
    if (mem_reqValid !== 1'b0) begin n_err++; $display("FAIL first_c1_reqValid: got %b, want 0", mem_reqValid); end
    tick;
    n_vec++;
    if ({mem_reqValid, mem_addr, mem_wen, mem_size} !== {1'b1, 32'h8000_0000, 1'b0, 2'd2}) begin
      n_err++; $display("FAIL first_c2_req: got v=%b a=%h w=%b s=%0d, want v=1 a=80000000 w=0 s=2",
                        mem_reqValid, mem_addr, mem_wen, mem_size);
    end
    tick;
    n_vec++;
    if ({ifu_respValid, mem_reqValid} !== 2'b00) begin n_err++; $display("FAIL first_c3: got resp=%b req=%b, want 0 0", ifu_respValid, mem_reqValid); end
    tick;
    n_vec++;
    if ({ifu_respValid, ifu_rdata} !== {1'b1, 32'h13}) begin
      n_err++; $display("FAIL first_c4_resp: got v=%b d=%h, want v=1 d=00000013", ifu_respValid, ifu_rdata);
    end
    tick;
    n_vec++;
    if ({ifu_respValid, lsu_respValid} !== 2'b00) begin n_err++; $display("FAIL first_c5_pulse: got ifu=%b lsu=%b, want 0 0", ifu_respValid, lsu_respValid); end
  endtask

  task automatic test_simultaneous;
    do_reset; resp_delay = 0;
    ifu_reqValid = 1; ifu_addr = 32'h100;
    lsu_reqValid = 1; lsu_addr = 32'h200; lsu_wen = 1; lsu_size = 2;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    tick; ifu_reqValid = 0; lsu_reqValid = 0;
    for (int i = 0; i < 100 && rsp_q.size() < 2; i++) tick;
    repeat (5) tick;
    n_vec++;
    if (rsp_q.size() != 2) begin n_err++; $display("FAIL sim_rsp_count: got %0d, want 2", rsp_q.size()); end
    else begin
      n_vec++;
      if ({rsp_q[0].ch, rsp_q[1].ch} !== 2'b10) begin n_err++; $display("FAIL sim_rsp_order: got %b%b, want lsu(1) then ifu(0)", rsp_q[0].ch, rsp_q[1].ch); end
      n_vec++;
      if (rsp_q[1].data !== 32'hA5A5_A4A5) begin n_err++; $display("FAIL sim_ifu_rdata: got %h, want a5a5a4a5", rsp_q[1].data); end
    end
    n_vec++;
    if (hs_q.size() != 2) begin n_err++; $display("FAIL sim_hs_count: got %0d, want 2", hs_q.size()); end
    else begin
      n_vec++;
      if ({hs_q[0].addr, hs_q[0].wen, hs_q[0].size, hs_q[0].wdata, hs_q[0].wmask} !==
          {32'h200, 1'b1, 2'd2, 32'hDEAD_BEEF, 4'hF}) begin
        n_err++; $display("FAIL sim_hs_lsu: got a=%h w=%b s=%0d d=%h m=%h, want a=200 w=1 s=2 d=deadbeef m=f",
                          hs_q[0].addr, hs_q[0].wen, hs_q[0].size, hs_q[0].wdata, hs_q[0].wmask);
      end
      n_vec++;
      if ({hs_q[1].addr, hs_q[1].wen, hs_q[1].size, hs_q[1].wdata, hs_q[1].wmask} !==
          {32'h100, 1'b0, 2'd2, 32'h0, 4'h0}) begin
        n_err++; $display("FAIL sim_hs_ifu: got a=%h w=%b s=%0d d=%h m=%h, want a=100 w=0 s=2 d=0 m=0",
                          hs_q[1].addr, hs_q[1].wen, hs_q[1].size, hs_q[1].wdata, hs_q[1].wmask);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset; resp_delay = 0; mem_reqReady = 0;
    lsu_reqValid = 1; lsu_addr = 32'h400; lsu_wen = 1; lsu_size = 1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
    tick; lsu_reqValid = 0;
    tick;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({mem_reqValid, mem_addr, mem_wdata, mem_wmask, mem_size} !== {1'b1, 32'h400, 32'h1234_5678, 4'h3, 2'd1}) begin
        n_err++; $display("FAIL bp_hold cycle %0d: got v=%b a=%h d=%h m=%h s=%0d, want v=1 a=400 d=12345678 m=3 s=1",
                          i, mem_reqValid, mem_addr, mem_wdata, mem_wmask, mem_size);
      end
      tick;
    end
    mem_reqReady = 1;
    for (int i = 0; i < 100 && rsp_q.size() < 1; i++) tick;
    repeat (3) tick;
    n_vec++;
    if (rsp_q.size() != 1) begin n_err++; $display("FAIL bp_rsp_count: got %0d, want 1", rsp_q.size()); end
    else begin
      n_vec++;
      if ({rsp_q[0].ch, rsp_q[0].data} !== {1'b1, 32'hA5A5_A1A5}) begin
        n_err++; $display("FAIL bp_rsp: got ch=%b d=%h, want ch=1 d=a5a5a1a5", rsp_q[0].ch, rsp_q[0].data);
      end
    end
  endtask

  task automatic test_pending;
    do_reset; resp_delay = 10;
    lsu_reqValid = 1; lsu_addr = 32'h300; lsu_wen = 0; lsu_size = 2; lsu_wmask = 0;
    tick; lsu_reqValid = 0;
    tick; tick; tick;
    ifu_reqValid = 1; ifu_addr = 32'h104;
    tick; ifu_reqValid = 0;
    for (int i = 0; i < 200 && rsp_q.size() < 2; i++) tick;
    repeat (3) tick;
    n_vec++;
    if (rsp_q.size() != 2 || hs_q.size() != 2) begin
      n_err++; $display("FAIL pend_counts: got rsp=%0d hs=%0d, want 2 2", rsp_q.size(), hs_q.size());
    end else begin
      n_vec++;
      if ({rsp_q[0].ch, rsp_q[0].data} !== {1'b1, 32'h1122_3344}) begin
        n_err++; $display("FAIL pend_lsu_rsp: got ch=%b d=%h, want ch=1 d=11223344", rsp_q[0].ch, rsp_q[0].data);
      end
      n_vec++;
      if ({rsp_q[1].ch, rsp_q[1].data} !== {1'b0, 32'h5566_7788}) begin
        n_err++; $display("FAIL pend_ifu_rsp: got ch=%b d=%h, want ch=0 d=55667788", rsp_q[1].ch, rsp_q[1].data);
      end
      n_vec++;
      if (hs_q[1].cyc - rsp_q[0].cyc != 1) begin
        n_err++; $display("FAIL pend_gap: got ifu req %0d cycles after lsu resp, want 1", hs_q[1].cyc - rsp_q[0].cyc);
      end
    end
  endtask

  task automatic test_fairness;
    do_reset; resp_delay = 0;
    lsu_wen = 0; lsu_size = 2;
    ifu_reqValid = 1; ifu_addr = 32'h1000;
    lsu_reqValid = 1; lsu_addr = 32'h2000;
    tick;
    for (int i = 1; i < 400 && hs_q.size() < 8; i++) begin
      ifu_reqValid = ifu_respValid; ifu_addr = 32'h1000 + i * 4;
      lsu_reqValid = lsu_respValid; lsu_addr = 32'h2000 + i * 4;
      tick;
    end
    ifu_reqValid = 0; lsu_reqValid = 0;
    repeat (40) tick;
    n_vec++;
    if (hs_q.size() < 8) begin n_err++; $display("FAIL fair_count: got %0d grants, want >= 8", hs_q.size()); end
    else for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = hs_q[k].addr;
      n_vec++;
      if (a[13] !== ((k % 2) == 0)) begin
        n_err++; $display("FAIL fair_grant %0d: got addr %h (lsu=%b), want lsu=%b", k, a, a[13], (k % 2) == 0);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    do_reset; resp_delay = 6;
    lsu_reqValid = 1; lsu_addr = 32'h500; lsu_wen = 0; lsu_size = 2;
    tick; lsu_reqValid = 0;
    tick; tick; tick;
    ifu_reqValid = 1; ifu_addr = 32'h104;
    tick; ifu_reqValid = 0;
    reset = 0; tick; tick;
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      tick;
      n_vec++;
      if ({ifu_respValid, lsu_respValid, mem_reqValid} !== 3'b000) begin
        n_err++; $display("FAIL rstmid_quiet cycle %0d: got ifu=%b lsu=%b req=%b, want 0 0 0",
                          i, ifu_respValid, lsu_respValid, mem_reqValid);
      end
    end
    n_vec++;
    if (rsp_q.size() != 0 || hs_q.size() != 1) begin
      n_err++; $display("FAIL rstmid_totals: got rsp=%0d hs=%0d, want 0 1", rsp_q.size(), hs_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_simultaneous;
    test_backpressure;
    test_pending;
    test_fairness;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
